// File: rtl/inst_constraint_chk.sv
// ---------------------------------------------------------------------------
// inst_constraint_chk
//
// Decode-stage legality checker for SPARC V9 instruction words. Each word is
// classified combinationally as allowed or disallowed against the supported
// subset:
//   * op=00 : BPcc, Bicc, BPr, SETHI/NOP (no register restriction)
//   * op=10 : a fixed ALU/multiply op3 set, all registers in r0-r15
//   * op=11 : any memory op3, all registers in r0-r15
//   * op=01 : CALL, never allowed
// When the decoder marks an instruction valid and it is disallowed, a one-
// cycle violation pulse, a sticky flag, a saturating counter and a capture
// of the first offending word are updated.
//
// Ports:
//   clk             in   decoder clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   dec_valid_d     in   decode-stage valid for the current instruction
//   instruction     in   [32:0] word; [31:0] SPARC encoding, [32] tag bit
//   allowed_op0     out  combinational op=00 legality term
//   allowed_op2     out  combinational op=10 legality term
//   allowed_op3     out  combinational op=11 legality term
//   inst_allowed    out  combinational OR of the three terms
//   viol_q          out  registered; 1 for one cycle after a violation
//   viol_sticky     out  set on the first violation, cleared by reset
//   viol_cnt        out  [CNT_W-1:0] saturating violation count
//   first_viol_inst out  [32:0] instruction captured at the first violation
// ---------------------------------------------------------------------------
module inst_constraint_chk #(
    parameter int unsigned EN_OP0 = 1,
    parameter int unsigned EN_OP2 = 1,
    parameter int unsigned EN_OP3 = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_d,
    input  logic [32:0]      instruction,
    output logic             allowed_op0,
    output logic             allowed_op2,
    output logic             allowed_op3,
    output logic             inst_allowed,
    output logic             viol_q,
    output logic             viol_sticky,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [32:0]      first_viol_inst
);

    // -----------------------------------------------------------------------
    // Field decode
    // -----------------------------------------------------------------------
    logic [1:0] op;
    logic [4:0] rd;
    logic [2:0] op2;
    logic [5:0] op3;
    logic [4:0] rs1;
    logic       imm_sel;
    logic [4:0] rs2;

    assign op      = instruction[31:30];
    assign rd      = instruction[29:25];
    assign op2     = instruction[24:22];
    assign op3     = instruction[24:19];
    assign rs1     = instruction[18:14];
    assign imm_sel = instruction[13];
    assign rs2     = instruction[4:0];

    // -----------------------------------------------------------------------
    // Legality lookup tables, built as constant bit-vectors indexed by the
    // opcode field so the supported set is visible in one place.
    // -----------------------------------------------------------------------
    logic [7:0]  op2_ok_vec;
    logic [63:0] op3_ok_vec;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_op2_tbl
            // 001 BPcc, 010 Bicc, 011 BPr, 100 SETHI/NOP
            assign op2_ok_vec[gi] = (gi >= 1) && (gi <= 4);
        end
        for (genvar gi = 0; gi < 64; gi++) begin : g_op3_tbl
            // 0x00-0x0C: ADD..SUBC; 0x10-0x18, 0x1A-0x1C: cc variants.
            // 0x19 and 0x0D-0x0F are holes in the supported set.
            assign op3_ok_vec[gi] = (gi <= 12) ||
                                    ((gi >= 16) && (gi <= 24)) ||
                                    ((gi >= 26) && (gi <= 28));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Register-range predicate: only the original half of the register file
    // (r0-r15) may be referenced. rs2 is irrelevant when the immediate form
    // is selected, because bits [4:0] then belong to simm13.
    // -----------------------------------------------------------------------
    logic rd_ok;
    logic rs1_ok;
    logic rs2_ok;
    logic regs_ok;

    assign rd_ok   = ~rd[4];
    assign rs1_ok  = ~rs1[4];
    assign rs2_ok  = imm_sel | ~rs2[4];
    assign regs_ok = rd_ok & rs1_ok & rs2_ok;

    // -----------------------------------------------------------------------
    // Per-format legality terms
    // -----------------------------------------------------------------------
    logic en_op0;
    logic en_op2;
    logic en_op3;

    assign en_op0 = (EN_OP0 != 0);
    assign en_op2 = (EN_OP2 != 0);
    assign en_op3 = (EN_OP3 != 0);

    assign allowed_op0  = en_op0 & (op == 2'b00) & op2_ok_vec[op2];
    assign allowed_op2  = en_op2 & (op == 2'b10) & op3_ok_vec[op3] & regs_ok;
    assign allowed_op3  = en_op3 & (op == 2'b11) & regs_ok;
    // op=01 (CALL) contributes no term, so it is always disallowed.
    assign inst_allowed = allowed_op0 | allowed_op2 | allowed_op3;

    // -----------------------------------------------------------------------
    // Violation tracking
    // -----------------------------------------------------------------------
    logic             viol_ev;
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [32:0]      first_q;
    logic [32:0]      first_d;

    assign viol_ev = dec_valid_d & ~inst_allowed;

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        if (viol_ev) begin
            sticky_d = 1'b1;
            // Saturate instead of wrapping so a long run of violations can
            // never read back as a small count.
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Only the first offending word is kept; sticky_q still low
            // means no capture has happened since reset.
            if (!sticky_q) begin
                first_d = instruction;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
        end else begin
            viol_q   <= viol_ev;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
        end
    end

    assign viol_sticky     = sticky_q;
    assign viol_cnt        = cnt_q;
    assign first_viol_inst = first_q;

endmodule

// File: tb/tb_inst_constraint_chk.sv
module tb_inst_constraint_chk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid_d;
    logic [32:0] instruction;

    // Default-parameter instance
    logic        a_op0, a_op2, a_op3, a_allowed, a_viol, a_sticky;
    logic [15:0] a_cnt;
    logic [32:0] a_first;

    // Narrow-counter instance
    logic        b_op0, b_op2, b_op3, b_allowed, b_viol, b_sticky;
    logic [1:0]  b_cnt;
    logic [32:0] b_first;

    // All formats disabled
    logic        c_op0, c_op2, c_op3, c_allowed, c_viol, c_sticky;
    logic [15:0] c_cnt;
    logic [32:0] c_first;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_constraint_chk u_dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_d(dec_valid_d), .instruction(instruction),
        .allowed_op0(a_op0), .allowed_op2(a_op2), .allowed_op3(a_op3),
        .inst_allowed(a_allowed), .viol_q(a_viol), .viol_sticky(a_sticky),
        .viol_cnt(a_cnt), .first_viol_inst(a_first)
    );

    inst_constraint_chk #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .dec_valid_d(dec_valid_d), .instruction(instruction),
        .allowed_op0(b_op0), .allowed_op2(b_op2), .allowed_op3(b_op3),
        .inst_allowed(b_allowed), .viol_q(b_viol), .viol_sticky(b_sticky),
        .viol_cnt(b_cnt), .first_viol_inst(b_first)
    );

    inst_constraint_chk #(.EN_OP0(0), .EN_OP2(0), .EN_OP3(0)) u_dut_dis (
        .clk(clk), .rst_n(rst_n), .dec_valid_d(dec_valid_d), .instruction(instruction),
        .allowed_op0(c_op0), .allowed_op2(c_op2), .allowed_op3(c_op3),
        .inst_allowed(c_allowed), .viol_q(c_viol), .viol_sticky(c_sticky),
        .viol_cnt(c_cnt), .first_viol_inst(c_first)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a word at the falling edge and check the four combinational terms.
    task automatic comb(input string tag, input logic [32:0] w, input logic v,
                        input logic e0, input logic e2, input logic e3);
        @(negedge clk);
        instruction = w;
        dec_valid_d = v;
        #1;
        chk({tag, ".op0"}, 64'(a_op0), 64'(e0));
        chk({tag, ".op2"}, 64'(a_op2), 64'(e2));
        chk({tag, ".op3"}, 64'(a_op3), 64'(e3));
        chk({tag, ".allowed"}, 64'(a_allowed), 64'(e0 | e2 | e3));
        $display("step %s instr=0x%09h valid=%0b allowed=%0b", tag, w, v, a_allowed);
    endtask

    // Advance past the next rising edge and check the registered outputs.
    task automatic regs(input string tag, input logic v, input logic s,
                        input logic [15:0] c, input logic [32:0] f);
        @(posedge clk);
        #1;
        chk({tag, ".viol_q"}, 64'(a_viol), 64'(v));
        chk({tag, ".sticky"}, 64'(a_sticky), 64'(s));
        chk({tag, ".cnt"}, 64'(a_cnt), 64'(c));
        chk({tag, ".first"}, 64'(a_first), 64'(f));
    endtask

    initial begin
        rst_n       = 1'b0;
        dec_valid_d = 1'b0;
        instruction = '0;
        #3;
        chk("rst.viol_q", 64'(a_viol), 64'd0);
        chk("rst.sticky", 64'(a_sticky), 64'd0);
        chk("rst.cnt", 64'(a_cnt), 64'd0);
        chk("rst.first", 64'(a_first), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // NOP, ADD r1,r2,r3, then ADD with rd=17
        comb("nop", 33'h001000000, 1'b1, 1'b1, 1'b0, 1'b0);
        regs("nop", 1'b0, 1'b0, 16'd0, 33'h0);
        comb("add", 33'h082008003, 1'b1, 1'b0, 1'b1, 1'b0);
        regs("add", 1'b0, 1'b0, 16'd0, 33'h0);
        comb("add_rd17", 33'h0A2008003, 1'b1, 1'b0, 1'b0, 1'b0);
        regs("add_rd17", 1'b1, 1'b1, 16'd1, 33'h0A2008003);

        // op3=0x0D, not valid: pulse drops, nothing else moves
        comb("op3_0d", 33'h082688003, 1'b0, 1'b0, 1'b0, 1'b0);
        regs("op3_0d", 1'b0, 1'b1, 16'd1, 33'h0A2008003);

        // Combinational-only boundary vectors (valid low)
        comb("ld_r1", 33'h0C200A004, 1'b0, 1'b0, 1'b0, 1'b1);
        comb("ld_rs1_20", 33'h0C2052004, 1'b0, 1'b0, 1'b0, 1'b0);
        comb("ld_tag", 33'h1C200A004, 1'b0, 1'b0, 1'b0, 1'b1);
        comb("ld_rs2_16", 33'h0C2008010, 1'b0, 1'b0, 1'b0, 1'b0);
        comb("ld_simm16", 33'h0C200A010, 1'b0, 1'b0, 1'b0, 1'b1);
        comb("op3_0c", 33'h082600000, 1'b0, 1'b0, 1'b1, 1'b0);
        comb("op3_10", 33'h082800000, 1'b0, 1'b0, 1'b1, 1'b0);
        comb("op3_19", 33'h082C80000, 1'b0, 1'b0, 1'b0, 1'b0);
        comb("op3_1c", 33'h082E00000, 1'b0, 1'b0, 1'b1, 1'b0);
        comb("op3_1d", 33'h082E80000, 1'b0, 1'b0, 1'b0, 1'b0);
        comb("op2_000", 33'h000000000, 1'b0, 1'b0, 1'b0, 1'b0);
        comb("op2_001", 33'h000400000, 1'b0, 1'b1, 1'b0, 1'b0);
        comb("op2_101", 33'h001400000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Disabled instance rejects everything that is otherwise legal
        comb("dis_ld", 33'h0C200A004, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("dis_ld.allowed", 64'(c_allowed), 64'd0);
        chk("dis_ld.op3", 64'(c_op3), 64'd0);
        comb("dis_add", 33'h082008003, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis_add.op2", 64'(c_op2), 64'd0);
        comb("dis_nop", 33'h001000000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dis_nop.op0", 64'(c_op0), 64'd0);

        // Reset between phases
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2.cnt", 64'(a_cnt), 64'd0);
        chk("rst2.sticky", 64'(a_sticky), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CALL with valid low for 5 cycles: nothing registered
        for (int k = 0; k < 5; k++) begin
            comb("call_nv", 33'h040000000, 1'b0, 1'b0, 1'b0, 1'b0);
            regs("call_nv", 1'b0, 1'b0, 16'd0, 33'h0);
        end

        // 5 consecutive violations; first capture stays on the CALL word
        comb("call_v", 33'h040000000, 1'b1, 1'b0, 1'b0, 1'b0);
        regs("call_v", 1'b1, 1'b1, 16'd1, 33'h040000000);
        chk("sat1.cnt", 64'(b_cnt), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            comb("viol_more", 33'h0A2008003, 1'b1, 1'b0, 1'b0, 1'b0);
            regs("viol_more", 1'b1, 1'b1, 16'(k), 33'h040000000);
            chk("sat.cnt", 64'(b_cnt), 64'((k > 3) ? 3 : k));
            chk("sat.first", 64'(b_first), 64'h040000000);
        end

        // Mid-cycle asynchronous reset while a violation is being presented
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.viol_q", 64'(a_viol), 64'd0);
        chk("arst.sticky", 64'(a_sticky), 64'd0);
        chk("arst.cnt", 64'(a_cnt), 64'd0);
        chk("arst.first", 64'(a_first), 64'd0);
        chk("arst.sat_cnt", 64'(b_cnt), 64'd0);
        $display("step arst time=%0t cnt=%0d", $time, a_cnt);

        // Deassertion between edges updates nothing; next edge does
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel.cnt", 64'(a_cnt), 64'd0);
        chk("rel.viol_q", 64'(a_viol), 64'd0);
        regs("rel_edge", 1'b1, 1'b1, 16'd1, 33'h0A2008003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
